// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: three requester ports, the shared response and the memory side.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_write;
  logic [5:0]  req_op;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_req;
  logic        mem_write;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_fault;

  modport slave (
    input  req_valid, req_write, req_op, req_addr, req_wdata, mem_done, mem_rdata, mem_fault,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_req, mem_write, mem_op, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_op, req_addr, req_wdata, mem_done, mem_rdata, mem_fault,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_req, mem_write, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of three requesters access to a single memory port,
// with a bounded wait for completion and a one-cycle response pulse.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [1:0]  grant;
  logic        grant_vld;

  // Walk from the furthest candidate back to rr_q so the nearest valid index wins.
  always_comb begin
    logic [1:0] idx;
    grant     = 2'd0;
    grant_vld = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(rr_q) + k) % 3);
      if (bus.req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    fault_d       = fault_q;
    bus.req_ready = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          bus.req_ready = reset ? 3'b000 : (3'b001 << grant);
          grant_d       = grant;
          rr_d          = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
          write_d       = bus.req_write[grant];
          op_d          = bus.req_op[{grant, 1'b0} +: 2];
          addr_d        = bus.req_addr[{grant, 5'b0} +: 32];
          wdata_d       = bus.req_wdata[{grant, 5'b0} +: 32];
          cnt_d         = 8'd0;
          if (bus.req_op[{grant, 1'b0} +: 2] == 2'b11) begin
            fault_d = 1'b1;
            rdata_d = 32'd0;
            state_d = StResp;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 8'd1;
        // A completion arriving on the final allowed cycle beats the timeout.
        if (bus.mem_done) begin
          rdata_d = bus.mem_rdata;
          fault_d = bus.mem_fault;
          state_d = StResp;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = 32'd0;
          fault_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= 2'd0;
      grant_q <= 2'd0;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      op_q    <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign bus.mem_req    = (state_q == StBusy);
  assign bus.mem_write  = write_q;
  assign bus.mem_op     = op_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_valid = (state_q == StResp) ? (3'b001 << grant_q) : 3'b000;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = (state_q == StResp) && fault_q;

endmodule
